// File: rtl/gf2_kmul_pipe_pkg.sv
// Shared types and constants for the pipelined carry-less multiplier.
// Also holds a plain schoolbook reference product for models.
package gf2_pkg;

    typedef enum logic [1:0] {
        GF2_FULL  = 2'd0,
        GF2_HIGH  = 2'd1,
        GF2_LOW   = 2'd2,
        GF2_FIELD = 2'd3
    } gf2_mode_t;

    localparam logic [7:0] GF2_AES_POLY = 8'h1B;
    localparam int         GF2_MAX_W    = 32;

    // Operands narrower than GF2_MAX_W are zero-extended by the caller.
    function automatic logic [2*GF2_MAX_W-1:0] gf2_clmul_ref(
        input logic [GF2_MAX_W-1:0] a,
        input logic [GF2_MAX_W-1:0] b
    );
        logic [2*GF2_MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < GF2_MAX_W; i++) begin
            if (b[i]) p = p ^ ({{GF2_MAX_W{1'b0}}, a} << i);
        end
        return p;
    endfunction

endpackage

// File: rtl/gf2_kmul_pipe_if.sv
// Operand and result handshake bundle for gf2_kmul_pipe.
// The slave side is the multiplier; the master side feeds operands and consumes results.
interface gf2_kmul_pipe_if
    import gf2_pkg::*;
#(
    parameter int W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    gf2_mode_t        in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_y;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_y
    );
endinterface

// File: rtl/gf2_kmul_pipe_clmul.sv
// Combinational N x N schoolbook carry-less multiplier (2N-1 bit product).
module gf2_clmul_comb #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-2:0] p_o
);
    always_comb begin
        p_o = '0;
        for (int i = 0; i < N; i++) begin
            if (b_i[i]) p_o = p_o ^ ({{(N-1){1'b0}}, a_i} << i);
        end
    end
endmodule

// File: rtl/gf2_kmul_pipe.sv
// Pipelined carry-less multiplier: one-level Karatsuba over three half-width products,
// recombined and sliced (FULL/HIGH/LOW) or reduced mod x^W + POLY in the output stage.
module gf2_kmul_pipe
    import gf2_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] POLY = W'(GF2_AES_POLY)
) (
    input  logic           clk,
    input  logic           rst,
    gf2_kmul_pipe_if.slave bus
);
    localparam int H = W / 2;

    if (((W % 2) != 0) || (W < 4)) begin : g_chk_w
        $error("gf2_kmul_pipe: W must be even and >= 4");
    end
    if (POLY[0] != 1'b1) begin : g_chk_poly
        $error("gf2_kmul_pipe: POLY bit 0 must be 1");
    end

    logic [3:1]        vld_q, vld_d;
    logic              ld1, ld2, ld3;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    gf2_mode_t         m1_q, m1_d, m2_q, m2_d;
    logic [2:0][H-1:0] op_a, op_b;
    logic [2:0][W-2:0] prod, prod_q, prod_d;
    logic [W-2:0]      mid;
    logic [2*W-1:0]    c, red, y_ext, y_q, y_d;

    // Index 0 = low halves, 1 = folded halves, 2 = high halves.
    assign op_a = {a_q[W-1:H], a_q[W-1:H] ^ a_q[H-1:0], a_q[H-1:0]};
    assign op_b = {b_q[W-1:H], b_q[W-1:H] ^ b_q[H-1:0], b_q[H-1:0]};

    gf2_clmul_comb #(.N(H)) u_mul [2:0] (
        .a_i (op_a),
        .b_i (op_b),
        .p_o (prod)
    );

    always_comb begin
        mid = prod_q[0] ^ prod_q[1] ^ prod_q[2];
        c   = ({{(W+1){1'b0}}, prod_q[2]} << W)
            ^ ({{(W+1){1'b0}}, mid} << H)
            ^ {{(W+1){1'b0}}, prod_q[0]};
        // Fold from the top down so each step only touches lower coefficients.
        red = c;
        for (int i = 2*W-2; i >= W; i--) begin
            if (red[i]) begin
                red    = red ^ ({{W{1'b0}}, POLY} << (i - W));
                red[i] = 1'b0;
            end
        end
        y_ext = '0;
        case (m2_q)
            GF2_FULL:  y_ext          = c;
            GF2_HIGH:  y_ext[W-1:0]   = c[2*W-2:W-1];
            GF2_LOW:   y_ext[W-1:0]   = c[W-1:0];
            default:   y_ext[W-1:0]   = red[W-1:0];
        endcase
    end

    // A stage may load when empty or when the stage after it is loading.
    always_comb begin
        ld3      = !vld_q[3] || bus.out_ready;
        ld2      = !vld_q[2] || ld3;
        ld1      = !vld_q[1] || ld2;
        vld_d[1] = ld1 ? bus.in_valid : vld_q[1];
        vld_d[2] = ld2 ? vld_q[1]     : vld_q[2];
        vld_d[3] = ld3 ? vld_q[2]     : vld_q[3];
        a_d      = a_q;
        b_d      = b_q;
        m1_d     = m1_q;
        prod_d   = prod_q;
        m2_d     = m2_q;
        y_d      = y_q;
        if (ld1 && bus.in_valid) begin
            a_d  = bus.in_a;
            b_d  = bus.in_b;
            m1_d = bus.in_mode;
        end
        if (ld2 && vld_q[1]) begin
            prod_d = prod;
            m2_d   = m1_q;
        end
        if (ld3 && vld_q[2]) y_d = y_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m1_q   <= GF2_FULL;
            prod_q <= '0;
            m2_q   <= GF2_FULL;
            y_q    <= '0;
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            b_q    <= b_d;
            m1_q   <= m1_d;
            prod_q <= prod_d;
            m2_q   <= m2_d;
            y_q    <= y_d;
        end
    end

    assign bus.in_ready  = ld1;
    assign bus.out_valid = vld_q[3];
    assign bus.out_y     = y_q;

endmodule

// File: tb/tb_gf2_kmul_pipe.sv
// Scoreboard bench for gf2_kmul_pipe: a W=8 instance for directed vectors and a
// W=16 instance for a long random run, each with its own expected-result queue.
module tb_gf2_kmul_pipe;
    import gf2_pkg::*;

    typedef struct {
        logic [31:0] y;
        int          cyc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rmode8 = 0;
    int   rmode16 = 0;
    int   pidx = 0;
    bit   drop8 = 1'b0;
    bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_t q8[$];
    exp_t q16[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf2_kmul_pipe_if #(.W(8))  if8 ();
    gf2_kmul_pipe_if #(.W(16)) if16 ();

    gf2_kmul_pipe #(.W(8), .POLY(8'h1B)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    gf2_kmul_pipe #(.W(16), .POLY(16'h002B)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Reduction uses the full monic polynomial, so bit i clears itself.
    function automatic logic [31:0] exp_y(input logic [15:0] a, input logic [15:0] b,
                                          input gf2_mode_t m, input int w,
                                          input logic [15:0] poly);
        logic [63:0] c, r, msk;
        c   = gf2_clmul_ref(32'(a), 32'(b));
        msk = (64'd1 << w) - 64'd1;
        r   = c;
        for (int i = 2*w-2; i >= w; i--) begin
            if (r[i]) r = r ^ (((64'd1 << w) | 64'(poly)) << (i - w));
        end
        case (m)
            GF2_FULL: return c[31:0];
            GF2_HIGH: return 32'((c >> (w - 1)) & msk);
            GF2_LOW:  return 32'(c & msk);
            default:  return 32'(r & msk);
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        case (rmode8)
            0: if8.out_ready = 1'b1;
            1: begin if8.out_ready = pat[pidx % 6]; pidx++; end
            default: if8.out_ready = 1'b0;
        endcase
        if16.out_ready = (rmode16 == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    initial begin : mon8
        logic        stall_p;
        logic [15:0] y_p;
        exp_t        e;
        stall_p = 1'b0;
        y_p     = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                stall_p = 1'b0;
            end else begin
                if (stall_p) begin
                    chk("stall_valid8", 32'(if8.out_valid), 32'd1);
                    chk("stall_hold8", 32'(if8.out_y), 32'(y_p));
                end
                chk("in_ready8", 32'(if8.in_ready), 32'(!((q8.size() >= 3) && !if8.out_ready)));
                if (!if8.in_ready) drop8 = 1'b1;
                if (if8.out_valid && if8.out_ready) begin
                    if (q8.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra8 actual=%0h required=no_result", if8.out_y);
                    end else begin
                        e = q8.pop_front();
                        chk("y8", 32'(if8.out_y), e.y);
                        if (e.lat) chk("latency8", 32'(cyc - e.cyc), 32'd3);
                    end
                end
                stall_p = if8.out_valid && !if8.out_ready;
                y_p     = if8.out_y;
            end
        end
    end

    initial begin : mon16
        logic        stall_p;
        logic [31:0] y_p;
        exp_t        e;
        stall_p = 1'b0;
        y_p     = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                stall_p = 1'b0;
            end else begin
                if (stall_p) begin
                    chk("stall_valid16", 32'(if16.out_valid), 32'd1);
                    chk("stall_hold16", if16.out_y, y_p);
                end
                chk("in_ready16", 32'(if16.in_ready), 32'(!((q16.size() >= 3) && !if16.out_ready)));
                if (if16.out_valid && if16.out_ready) begin
                    if (q16.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra16 actual=%0h required=no_result", if16.out_y);
                    end else begin
                        e = q16.pop_front();
                        chk("y16", if16.out_y, e.y);
                    end
                end
                stall_p = if16.out_valid && !if16.out_ready;
                y_p     = if16.out_y;
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input gf2_mode_t m,
                         input logic [31:0] y, input bit lat);
        bit acc;
        int c0;
        acc = 1'b0;
        c0  = 0;
        @(negedge clk);
        if8.in_valid = 1'b1;
        if8.in_a     = a;
        if8.in_b     = b;
        if8.in_mode  = m;
        for (int t = 0; t < 64 && !acc; t++) begin
            #4;
            acc = if8.in_ready;
            c0  = cyc;
            @(posedge clk);
            if (acc) q8.push_back('{y, c0, lat});
            else @(negedge clk);
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept8 actual=timeout required=accepted a=%0h b=%0h", a, b);
        end
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input gf2_mode_t m,
                          input logic [31:0] y);
        bit acc;
        int c0;
        acc = 1'b0;
        c0  = 0;
        @(negedge clk);
        if16.in_valid = 1'b1;
        if16.in_a     = a;
        if16.in_b     = b;
        if16.in_mode  = m;
        for (int t = 0; t < 64 && !acc; t++) begin
            #4;
            acc = if16.in_ready;
            c0  = cyc;
            @(posedge clk);
            if (acc) q16.push_back('{y, c0, 1'b0});
            else @(negedge clk);
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept16 actual=timeout required=accepted a=%0h b=%0h", a, b);
        end
    endtask

    task automatic idle8();
        @(negedge clk);
        if8.in_valid = 1'b0;
    endtask

    task automatic drain8(input string nm);
        for (int t = 0; t < 300 && q8.size() != 0; t++) @(negedge clk);
        if (q8.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=%0d_pending required=0_pending", nm, q8.size());
            q8.delete();
        end
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0]  ta [6];
        logic [7:0]  tb [6];
        gf2_mode_t   tm [6];
        logic [15:0] a16, b16;
        gf2_mode_t   m16;

        ta = '{8'h57, 8'hFF, 8'h80, 8'h00, 8'hC3, 8'h1B};
        tb = '{8'h83, 8'h01, 8'h80, 8'hA5, 8'h3C, 8'hFF};
        tm = '{GF2_FULL, GF2_HIGH, GF2_LOW, GF2_FIELD, GF2_FULL, GF2_FIELD};

        if8.in_valid   = 1'b0;
        if8.in_a       = '0;
        if8.in_b       = '0;
        if8.in_mode    = GF2_FULL;
        if8.out_ready  = 1'b1;
        if16.in_valid  = 1'b0;
        if16.in_a      = '0;
        if16.in_b      = '0;
        if16.in_mode   = GF2_FULL;
        if16.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #4;
        chk("reset_out_valid8", 32'(if8.out_valid), 32'd0);
        chk("reset_out_y8", 32'(if8.out_y), 32'd0);
        chk("reset_in_ready8", 32'(if8.in_ready), 32'd1);
        chk("reset_out_valid16", 32'(if16.out_valid), 32'd0);

        // Single FULL beat with latency check, then the other modes back-to-back.
        send8(8'h57, 8'h83, GF2_FULL, 32'h2B79, 1'b1);
        idle8();
        drain8("drain_t1");
        send8(8'h57, 8'h83, GF2_HIGH,  32'h56, 1'b1);
        send8(8'h57, 8'h83, GF2_LOW,   32'h79, 1'b1);
        send8(8'h57, 8'h83, GF2_FIELD, 32'hC1, 1'b1);
        send8(8'h00, 8'h5A, GF2_FIELD, 32'h00, 1'b1);
        send8(8'h5A, 8'h00, GF2_FULL,  32'h00, 1'b1);
        idle8();
        drain8("drain_t2");

        for (int i = 0; i < 8; i++) begin
            send8(8'hFF, 8'hFF, (i % 2 == 1) ? GF2_HIGH : GF2_FULL,
                  (i % 2 == 1) ? 32'hAA : 32'h5555, 1'b1);
        end
        idle8();
        drain8("drain_t3");

        drop8  = 1'b0;
        pidx   = 0;
        rmode8 = 1;
        for (int i = 0; i < 6; i++) begin
            send8(ta[i], tb[i], tm[i], exp_y({8'h00, ta[i]}, {8'h00, tb[i]}, tm[i], 8, 16'h001B), 1'b0);
        end
        idle8();
        drain8("drain_t4");
        chk("t4_in_ready_dropped", 32'(drop8), 32'd1);

        // Three beats held under backpressure, then a one-cycle reset.
        rmode8 = 2;
        @(negedge clk);
        send8(8'h11, 8'h22, GF2_FULL, 32'h0, 1'b0);
        send8(8'h33, 8'h44, GF2_LOW,  32'h0, 1'b0);
        send8(8'h55, 8'h66, GF2_HIGH, 32'h0, 1'b0);
        @(negedge clk);
        rst          = 1'b1;
        if8.in_valid = 1'b0;
        q8.delete();
        @(negedge clk);
        rst    = 1'b0;
        rmode8 = 0;
        #4;
        chk("t5_out_valid", 32'(if8.out_valid), 32'd0);
        chk("t5_out_y", 32'(if8.out_y), 32'd0);
        chk("t5_in_ready", 32'(if8.in_ready), 32'd1);
        send8(8'h57, 8'h83, GF2_FIELD, 32'hC1, 1'b1);
        idle8();
        drain8("drain_t5");

        rmode16 = 1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                if16.in_valid = 1'b0;
                if16.in_a     = 16'($urandom);
            end
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            if ($urandom_range(0, 15) == 0) a16 = '0;
            m16 = gf2_mode_t'($urandom_range(0, 3));
            send16(a16, b16, m16, exp_y(a16, b16, m16, 16, 16'h002B));
        end
        @(negedge clk);
        if16.in_valid = 1'b0;
        for (int t = 0; t < 300 && q16.size() != 0; t++) @(negedge clk);
        if (q16.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_t6 actual=%0d_pending required=0_pending", q16.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
